// File: rtl/mips_alu_1bit_pkg.sv
// mips_alu_1bit_pkg: opcode constants and field positions for the 1-bit ALU slice
package mips_alu_1bit_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam int BINV_BIT = 2;
    localparam int FSEL_HI  = 1;
    localparam int FSEL_LO  = 0;
    typedef enum logic [1:0] {F_AND = 2'b00, F_OR = 2'b01, F_ADD = 2'b10, F_LESS = 2'b11} fsel_t;
endpackage

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: one-bit full adder
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/mips_alu_1bit.sv
// mips_alu_1bit: registered one-bit MIPS ALU slice (AND/OR/ADD/SUB/SLT)
module mips_alu_1bit
    import mips_alu_1bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bi,
    input  logic [2:0] aluOp,
    input  logic       ai,
    input  logic       ci,
    input  logic       lessi,
    output logic       ri,
    output logic       ci_1
);
    logic  b_eff, sum, cout, r;
    fsel_t fsel;
    assign b_eff = bi ^ aluOp[BINV_BIT];
    assign fsel  = fsel_t'(aluOp[FSEL_HI:FSEL_LO]);
    full_adder_1bit u_fa (.a(ai), .b(b_eff), .cin(ci), .s(sum), .cout(cout));
    always_comb begin
        r = fsel == F_AND ? ai & b_eff :
            fsel == F_OR  ? ai | b_eff :
            fsel == F_ADD ? sum : lessi;
    end
    // carry-out is registered for every op so the ripple chain never depends on the function select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ri   <= 1'b0;
            ci_1 <= 1'b0;
        end else begin
            ri   <= r;
            ci_1 <= cout;
        end
    end
endmodule

// File: tb/tb_mips_alu_1bit.sv
// tb_mips_alu_1bit: directed + randomized checks of mips_alu_1bit against an arithmetic reference
module tb_mips_alu_1bit;
    logic       clk = 0, rst_n = 0, bi = 1, ai = 1, ci = 1, lessi = 0;
    logic [2:0] aluOp = 3'b010;
    logic       ri, ci_1;
    int         tests = 0, fails = 0;
    logic [1:0] e;

    mips_alu_1bit dut (.clk(clk), .rst_n(rst_n), .bi(bi), .aluOp(aluOp), .ai(ai),
                       .ci(ci), .lessi(lessi), .ri(ri), .ci_1(ci_1));

    always #5 clk = ~clk;

    // returns {result, carry}: treats bits as integers and adds them
    function automatic logic [1:0] ref_alu(input logic [2:0] op, input logic a, b, c, l);
        int be, t, r;
        be = op[2] ? 1 - int'(b) : int'(b);
        t  = int'(a) + be + int'(c);
        case (int'(op[1:0]))
            0: r = int'(a) * be;
            1: r = (int'(a) + be > 0) ? 1 : 0;
            2: r = t % 2;
            default: r = int'(l);
        endcase
        return {r[0], t >= 2};
    endfunction

    task automatic check(input string tag, input logic er, input logic ec);
        tests++;
        assert (ri === er && ci_1 === ec)
        else begin
            fails++;
            $error("FAIL %s: got ri=%b ci_1=%b, expected ri=%b ci_1=%b", tag, ri, ci_1, er, ec);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic a, b, c, l);
        @(negedge clk);
        aluOp = op; ai = a; bi = b; ci = c; lessi = l;
    endtask

    task automatic run_exp(input string tag, input logic [2:0] op, input logic a, b, c, l,
                           input logic er, input logic ec);
        drive(op, a, b, c, l);
        @(posedge clk); #1;
        check(tag, er, ec);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic a, b, c, l);
        logic [1:0] x;
        x = ref_alu(op, a, b, c, l);
        run_exp(tag, op, a, b, c, l, x[1], x[0]);
    endtask

    initial begin
        #1 check("reset_immediate", 1'b0, 1'b0);
        @(posedge clk); #1 check("reset_held_over_edge", 1'b0, 1'b0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1 check("first_after_release", 1'b1, 1'b1);

        run_exp("and_11", 3'b000, 1, 1, 0, 0, 1, 1);
        run_exp("or_11",  3'b001, 1, 1, 0, 0, 1, 1);
        run_exp("and_00", 3'b000, 0, 0, 0, 0, 0, 0);
        run_exp("or_00",  3'b001, 0, 0, 0, 0, 0, 0);
        run_exp("and_10", 3'b000, 1, 0, 0, 0, 0, 0);
        run_exp("or_10",  3'b001, 1, 0, 0, 0, 1, 0);
        run_exp("or_10_ci", 3'b001, 1, 0, 1, 0, 1, 1);
        run_exp("add_110", 3'b010, 1, 1, 0, 0, 0, 1);
        run_exp("add_111", 3'b010, 1, 1, 1, 0, 1, 1);
        run_exp("add_011", 3'b010, 0, 1, 1, 0, 0, 1);
        run_exp("add_000", 3'b010, 0, 0, 0, 0, 0, 0);
        // a + ~b + 1 with 1-bit operands
        run_exp("sub_00", 3'b110, 0, 0, 1, 0, 0, 1);
        run_exp("sub_01", 3'b110, 0, 1, 1, 0, 1, 0);
        run_exp("sub_11", 3'b110, 1, 1, 1, 0, 0, 1);
        run_exp("sub_10", 3'b110, 1, 0, 1, 0, 1, 1);
        run_exp("slt_10_l0", 3'b111, 1, 0, 0, 0, 0, 1);
        run_exp("slt_01_l0", 3'b111, 0, 1, 0, 0, 0, 0);
        run_exp("slt_01_l1", 3'b111, 0, 1, 0, 1, 1, 0);
        run_exp("op011_less", 3'b011, 1, 1, 0, 1, 1, 1);

        for (int k = 0; k < 128; k++)
            run($sformatf("exh_%0d", k), k[6:4], k[3], k[2], k[1], k[0]);

        for (int k = 0; k < 200; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            run($sformatf("rand_%0d", k), v[2:0], v[3], v[4], v[5], v[6]);
        end

        // mid-cycle input change must not disturb outputs until the next edge
        run_exp("lat_base", 3'b010, 1, 1, 1, 0, 1, 1);
        #2; aluOp = 3'b000; ai = 0; bi = 0; ci = 0;
        #1 check("lat_hold", 1'b1, 1'b1);
        @(negedge clk); check("lat_hold_negedge", 1'b1, 1'b1);
        @(posedge clk); #1 check("lat_update", 1'b0, 1'b0);
        @(negedge clk); check("lat_once", 1'b0, 1'b0);

        // asynchronous reset mid-operation discards the pending result
        run_exp("mid_base", 3'b001, 1, 0, 0, 0, 1, 0);
        drive(3'b010, 1, 1, 1, 0);
        #1 rst_n = 0;
        #1 check("mid_reset_async", 1'b0, 1'b0);
        @(posedge clk); #1 check("mid_reset_edge", 1'b0, 1'b0);
        @(negedge clk); rst_n = 1; #1 check("mid_release_hold", 1'b0, 1'b0);
        @(posedge clk); #1 check("mid_release_edge", 1'b1, 1'b1);

        e = ref_alu(3'b101, 0, 1, 0, 0);
        run_exp("op101_model", 3'b101, 0, 1, 0, 0, e[1], e[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
